// File: rtl/ifu_fetch_queue_pkg.sv
// ----------------------------------------------------------------------------
// ifu_fetch_queue_pkg
//   Shared types for the IFU fetch queue:
//     XLEN, INSTR_LEN   - PC and instruction widths
//     fetchq_entry_t    - one queued instruction together with its PC
//     fetchq_state_t    - fetch FSM states (BOOT, RUN)
// ----------------------------------------------------------------------------
package ifu_fetch_queue_pkg;

    localparam int XLEN      = 32;
    localparam int INSTR_LEN = 32;

    typedef struct packed {
        logic [INSTR_LEN-1:0] instr;
        logic [XLEN-1:0]      pc;
    } fetchq_entry_t;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetchq_state_t;

endpackage

// File: rtl/ifu_fetch_queue_fifo.sv
// ----------------------------------------------------------------------------
// ifu_fetch_queue_fifo
//   DEPTH-entry FIFO of fetchq_entry_t with synchronous clear.
//   Ports:
//     clk, rst      - clock, asynchronous active-high reset
//     push, wdata   - write request and entry
//     pop           - read request (ignored when empty)
//     clear         - discard all entries; wins over push and pop
//     rdata         - head entry (only meaningful when !empty)
//     full, empty   - occupancy flags
//     count         - number of stored entries (0..DEPTH)
// ----------------------------------------------------------------------------
module ifu_fetch_queue_fifo
    import ifu_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  fetchq_entry_t          wdata,
    input  logic                   pop,
    input  logic                   clear,
    output fetchq_entry_t          rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetchq_entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !clear;
    // A push at full is accepted only when the head leaves in the same cycle.
    assign do_push = push && !clear && (!full || pop);
    assign rdata   = mem[rd_ptr];

    // NOTE: the storage array has no reset; entries are only observed after
    // being written, so resetting them would add muxes for no benefit.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (rst) !(push && !clear && full && !pop));

endmodule

// File: rtl/ifu_fetch_queue.sv
// ----------------------------------------------------------------------------
// ifu_fetch_queue
//   Decoupling queue between the ICCM and the IFU/IDU0 boundary. Issues
//   sequential word fetches while credits remain, buffers in-order responses
//   with their PCs and presents them on a valid/ready interface. A redirect
//   (flush) empties the queue, toggles the epoch bit so in-flight responses
//   are recognised as stale, and restarts fetching at redirect_pc.
//
//   Build option: define FETCHQ_BYPASS_EN to forward a fresh response straight
//   to instr/instr_pc/instr_valid when the queue is empty (0-cycle latency).
//   Without it every instruction goes through queue storage (1-cycle latency).
//
//   Ports:
//     clk, rst          - clock, asynchronous active-high reset
//     reset_vector      - boot PC, loaded during the BOOT cycle
//     flush, redirect_pc- redirect request and new PC
//     mem_addr          - ICCM word address (fetch_pc[ADDR_WIDTH+1:2])
//     mem_addr_valid    - fetch request strobe
//     mem_tag_out       - request tag {epoch, fetch_pc}
//     mem_rdata         - returned instruction
//     mem_rdata_valid   - response strobe
//     mem_tag_in        - returned tag
//     instr, instr_pc   - head instruction and its PC
//     instr_valid       - head valid
//     instr_ready       - consumer accepts the head
// ----------------------------------------------------------------------------
module ifu_fetch_queue
    import ifu_fetch_queue_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int TAG_WIDTH  = XLEN + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [XLEN-1:0]       reset_vector,
    input  logic                  flush,
    input  logic [XLEN-1:0]       redirect_pc,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_addr_valid,
    output logic [TAG_WIDTH-1:0]  mem_tag_out,
    input  logic [INSTR_LEN-1:0]  mem_rdata,
    input  logic                  mem_rdata_valid,
    input  logic [TAG_WIDTH-1:0]  mem_tag_in,
    output logic [INSTR_LEN-1:0]  instr,
    output logic [XLEN-1:0]       instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetchq_state_t   state;
    logic [XLEN-1:0] fetch_pc;
    logic            epoch;
    logic [CW-1:0]   outstanding;

    logic            run;
    logic [CW-1:0]   count;
    logic [CW-1:0]   credits;
    logic            issue;
    logic            resp;
    logic            fresh;
    logic            push;
    logic            pop;
    logic            q_empty;
    logic            q_full;
    fetchq_entry_t   q_head;
    fetchq_entry_t   q_wdata;

    assign run = (state == RUN);

    // Every queue slot is either occupied or reserved by an in-flight request,
    // so the queue can never overflow.
    assign credits = CW'(DEPTH) - count - outstanding;
    assign issue   = run && !flush && (credits != '0);
    // Responses are ignored in BOOT: anything arriving then predates reset.
    assign resp    = run && mem_rdata_valid;
    // Responses tagged with an old epoch were fetched before a redirect.
    assign fresh   = resp && !flush && (mem_tag_in[TAG_WIDTH-1] == epoch);
    assign q_wdata = '{instr: mem_rdata, pc: mem_tag_in[XLEN-1:0]};
    assign pop     = run && !flush && !q_empty && instr_ready;

    assign mem_addr       = fetch_pc[ADDR_WIDTH+1:2];
    assign mem_addr_valid = issue;
    assign mem_tag_out    = {epoch, fetch_pc};

`ifdef FETCHQ_BYPASS_EN
    logic bypass;

    assign bypass      = fresh && q_empty;
    // A bypassed response consumed this cycle never touches storage.
    assign push        = fresh && !(bypass && instr_ready);
    assign instr_valid = !q_empty || bypass;
    assign instr       = !q_empty ? q_head.instr : (bypass ? mem_rdata : '0);
    assign instr_pc    = !q_empty ? q_head.pc
                                  : (bypass ? mem_tag_in[XLEN-1:0] : '0);
`else
    assign push        = fresh;
    assign instr_valid = !q_empty;
    assign instr       = q_empty ? '0 : q_head.instr;
    assign instr_pc    = q_empty ? '0 : q_head.pc;
`endif

    ifu_fetch_queue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (q_wdata),
        .pop   (pop),
        .clear (run && flush),
        .rdata (q_head),
        .full  (q_full),
        .empty (q_empty),
        .count (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            fetch_pc    <= '0;
            epoch       <= 1'b0;
            outstanding <= '0;
        end else begin
            case (state)
                BOOT: begin
                    fetch_pc <= reset_vector;
                    state    <= RUN;
                end
                RUN: begin
                    if (flush) begin
                        fetch_pc <= redirect_pc;
                        epoch    <= ~epoch;
                    end else if (issue) begin
                        fetch_pc <= fetch_pc + XLEN'(4);
                    end
                    // Stale responses still return their credit.
                    case ({issue, resp})
                        2'b10:   outstanding <= outstanding + CW'(1);
                        2'b01:   outstanding <= outstanding - CW'(1);
                        default: ;
                    endcase
                end
                default: state <= BOOT;
            endcase
        end
    end

    a_outstanding_bound: assert property (
        @(posedge clk) disable iff (rst) outstanding <= CW'(DEPTH));

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst) !(push && q_full && !pop && !flush));

endmodule

// File: tb/tb_ifu_fetch_queue.sv
module tb_ifu_fetch_queue;
    import ifu_fetch_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 16;
    localparam int TW    = XLEN + 1;
`ifdef FETCHQ_BYPASS_EN
    localparam int L = 0;
`else
    localparam int L = 1;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [XLEN-1:0]      reset_vector = 32'h0000_0100;
    logic                 flush = 1'b0;
    logic [XLEN-1:0]      redirect_pc = '0;
    logic [AW-1:0]        mem_addr;
    logic                 mem_addr_valid;
    logic [TW-1:0]        mem_tag_out;
    logic [INSTR_LEN-1:0] mem_rdata = '0;
    logic                 mem_rdata_valid = 1'b0;
    logic [TW-1:0]        mem_tag_in = '0;
    logic [INSTR_LEN-1:0] instr;
    logic [XLEN-1:0]      instr_pc;
    logic                 instr_valid;
    logic                 instr_ready = 1'b0;

    always #5 clk = ~clk;

    ifu_fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) dut (
        .clk             (clk),
        .rst             (rst),
        .reset_vector    (reset_vector),
        .flush           (flush),
        .redirect_pc     (redirect_pc),
        .mem_addr        (mem_addr),
        .mem_addr_valid  (mem_addr_valid),
        .mem_tag_out     (mem_tag_out),
        .mem_rdata       (mem_rdata),
        .mem_rdata_valid (mem_rdata_valid),
        .mem_tag_in      (mem_tag_in),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ICCM contents: a fixed scramble of the PC.
    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'hA5A5_5A5A;
    endfunction

    // ICCM model: in-order responses after 'lat' cycles.
    typedef struct {
        logic [TW-1:0] tag;
        int            due;
    } req_t;
    req_t pend[$];
    int   cyc = 0;
    int   lat = 1;

    // Reference model of the request and delivery streams.
    logic [31:0] fpc_m   = '0;
    logic [31:0] exp_pc  = 32'h0000_0100;
    logic        epoch_m = 1'b0;
    logic        in_boot = 1'b1;
    int          n_issued = 0;
    int          n_deliv  = 0;

    logic        s_av;
    logic [AW-1:0] s_addr;
    logic        s_iv;
    logic [31:0] s_ipc;

    // One clock cycle: drive inputs at the falling edge, sample 1 ns later,
    // update the model, then wait for the next falling edge.
    task automatic step(input logic f, input logic [31:0] rpc, input logic rdy);
        flush           = f;
        redirect_pc     = rpc;
        instr_ready     = rdy;
        mem_rdata_valid = 1'b0;
        mem_tag_in      = '0;
        mem_rdata       = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_rdata_valid = 1'b1;
            mem_tag_in      = pend[0].tag;
            mem_rdata       = mem_word(pend[0].tag[31:0]);
            void'(pend.pop_front());
        end
        #1;
        s_av   = mem_addr_valid;
        s_addr = mem_addr;
        s_iv   = instr_valid;
        s_ipc  = instr_pc;

        if (in_boot) begin
            check("boot_no_req", mem_addr_valid, 1'b0);
            fpc_m   = reset_vector;
            in_boot = 1'b0;
        end else if (f) begin
            check("no_req_on_flush", mem_addr_valid, 1'b0);
        end else if (mem_addr_valid) begin
            check("req_addr", mem_addr, fpc_m[AW+1:2]);
            check("req_tag", mem_tag_out, {epoch_m, fpc_m});
            pend.push_back('{tag: mem_tag_out, due: cyc + lat});
            fpc_m = fpc_m + 32'd4;
            n_issued++;
        end

        if (instr_valid && rdy && !f) begin
            check("deliver_pc", instr_pc, exp_pc);
            check("deliver_instr", instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_deliv++;
        end else if (instr_valid && !rdy) begin
            check("hold_pc", instr_pc, exp_pc);
            check("hold_instr", instr, mem_word(exp_pc));
        end

        if (f) begin
            exp_pc   = rpc;
            fpc_m    = rpc;
            epoch_m  = ~epoch_m;
            n_issued = 0;
            n_deliv  = 0;
        end
        cyc++;
        @(negedge clk);
    endtask

    typedef struct {
        logic        ready;
        logic        exp_av;
        logic [15:0] exp_addr;
        logic        exp_iv;
        logic [31:0] exp_ipc;
    } vec_t;
    vec_t vec [8];

    initial begin
        int d0;

        // Boot sequence: reset_vector 0x100, 1-cycle ICCM, consumer always ready.
        vec[0] = '{ready: 1'b1, exp_av: 1'b0, exp_addr: 16'h0000, exp_iv: 1'b0,     exp_ipc: 32'h0};
        vec[1] = '{ready: 1'b1, exp_av: 1'b1, exp_addr: 16'h0040, exp_iv: 1'b0,     exp_ipc: 32'h0};
        vec[2] = '{ready: 1'b1, exp_av: 1'b1, exp_addr: 16'h0041, exp_iv: (L == 0), exp_ipc: 32'h100};
        vec[3] = '{ready: 1'b1, exp_av: 1'b1, exp_addr: 16'h0042, exp_iv: 1'b1,     exp_ipc: 32'h100 + 32'(4 * (1 - L))};
        vec[4] = '{ready: 1'b1, exp_av: 1'b1, exp_addr: 16'h0043, exp_iv: 1'b1,     exp_ipc: 32'h100 + 32'(4 * (2 - L))};
        vec[5] = '{ready: 1'b1, exp_av: 1'b1, exp_addr: 16'h0044, exp_iv: 1'b1,     exp_ipc: 32'h100 + 32'(4 * (3 - L))};
        vec[6] = '{ready: 1'b1, exp_av: 1'b1, exp_addr: 16'h0045, exp_iv: 1'b1,     exp_ipc: 32'h100 + 32'(4 * (4 - L))};
        vec[7] = '{ready: 1'b1, exp_av: 1'b1, exp_addr: 16'h0046, exp_iv: 1'b1,     exp_ipc: 32'h100 + 32'(4 * (5 - L))};

        #1 rst = 1'b1;
        #2;
        check("rst_addr_valid", mem_addr_valid, 1'b0);
        check("rst_addr", mem_addr, 16'h0);
        check("rst_tag", mem_tag_out, 33'h0);
        check("rst_instr_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            step(1'b0, 32'h0, vec[i].ready);
            check($sformatf("vec%0d_addr_valid", i), s_av, vec[i].exp_av);
            if (vec[i].exp_av) check($sformatf("vec%0d_addr", i), s_addr, vec[i].exp_addr);
            check($sformatf("vec%0d_instr_valid", i), s_iv, vec[i].exp_iv);
            if (vec[i].exp_iv) check($sformatf("vec%0d_instr_pc", i), s_ipc, vec[i].exp_ipc);
        end

        // Backpressure: queue fills to DEPTH, requests stop, head is held.
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0);
        check("bp_addr_valid_drops", s_av, 1'b0);
        check("bp_queued", n_issued - n_deliv, DEPTH);
        check("bp_head_valid", s_iv, 1'b1);
        d0 = n_deliv;
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);
        check("bp_release_no_gap", n_deliv - d0, 6);

        // Flush with two requests in flight (2-cycle ICCM).
        lat = 2;
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);
        check("inflight_two", pend.size(), 2);
        step(1'b1, 32'h0000_0200, 1'b1);
        step(1'b0, 32'h0, 1'b0);
        check("flush_queue_empty", s_iv, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b0, 32'h0, 1'b0);
        check("flush_credits_back", n_issued, DEPTH);
        check("flush_addr_valid_drops", s_av, 1'b0);
        check("flush_head_valid", s_iv, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
        check("flush_new_stream", n_deliv, 4);

        // Flush and pop at full queue, redirecting to a wrapping PC.
        lat = 1;
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0);
        check("full_before_flush", n_issued - n_deliv, DEPTH);
        step(1'b1, 32'hFFFF_FFFC, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        check("flush_full_empty", s_iv, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);
        check("wrap_deliveries", n_deliv, 5 - L);
        check("wrap_next_pc", exp_pc, 32'(4 * (4 - L)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
